// File: rtl/pipe_ctrl_pkg.sv
// Shared opcodes, field encodings and the control bundle carried down the
// 5-stage pipeline by pipe_ctrl_unit.
package pipe_ctrl_pkg;

    localparam int REG_W = 5;

    localparam logic [6:0] OP_R     = 7'b0110011;
    localparam logic [6:0] OP_I     = 7'b0010011;
    localparam logic [6:0] OP_LOAD  = 7'b0000011;
    localparam logic [6:0] OP_S     = 7'b0100011;
    localparam logic [6:0] OP_B     = 7'b1100011;
    localparam logic [6:0] OP_JAL   = 7'b1101111;
    localparam logic [6:0] OP_JALR  = 7'b1100111;
    localparam logic [6:0] OP_LUI   = 7'b0110111;
    localparam logic [6:0] OP_AUIPC = 7'b0010111;

    localparam logic [3:0] ALU_ADD   = 4'b0000;
    localparam logic [3:0] ALU_PASSB = 4'b1111;

    localparam logic [2:0] IMM_I = 3'b000;
    localparam logic [2:0] IMM_S = 3'b001;
    localparam logic [2:0] IMM_U = 3'b010;
    localparam logic [2:0] IMM_B = 3'b101;
    localparam logic [2:0] IMM_J = 3'b110;

    localparam logic [4:0] BR_NONE = 5'b00000;
    localparam logic [4:0] BR_JUMP = 5'b10000;

    localparam logic [1:0] WB_ALU = 2'b00;
    localparam logic [1:0] WB_MEM = 2'b01;
    localparam logic [1:0] WB_PC4 = 2'b10;

    localparam logic [1:0] FWD_RF  = 2'b00;
    localparam logic [1:0] FWD_MEM = 2'b01;
    localparam logic [1:0] FWD_WB  = 2'b10;

    typedef struct packed {
        logic             valid;
        logic             AluASrc;
        logic             AluBSrc;
        logic             RuWr;
        logic [2:0]       ImmSrc;
        logic [3:0]       ALUOp;
        logic [4:0]       BrOp;
        logic             DMWr;
        logic [2:0]       DMCtrl;
        logic [1:0]       RUDataWrSrc;
        logic [REG_W-1:0] rd;
        logic [REG_W-1:0] rs1;
        logic [REG_W-1:0] rs2;
    } ctrl_t;

    localparam ctrl_t CTRL_NOP = '0;

    // A producing stage feeds a source only when it really writes a non-x0 register.
    function automatic logic src_hit(input logic valid, input logic ru_wr,
                                     input logic [REG_W-1:0] prod_rd,
                                     input logic [REG_W-1:0] src);
        return valid & ru_wr & (prod_rd != '0) & (prod_rd == src);
    endfunction

endpackage

// File: rtl/pipe_ctrl_decode.sv
// Combinational ID-stage decoder: RV32I instruction fields to a ctrl_t bundle.
module pipe_ctrl_decode
    import pipe_ctrl_pkg::*;
(
    input  logic             id_valid,
    input  logic [6:0]       opcode,
    input  logic [2:0]       funct3,
    input  logic [6:0]       funct7,
    input  logic [REG_W-1:0] rs1,
    input  logic [REG_W-1:0] rs2,
    input  logic [REG_W-1:0] rd,
    output ctrl_t            ctrl,
    output logic             illegal
);

    logic use_rs1;
    logic use_rs2;
    logic unused_funct7;

    assign unused_funct7 = ^{funct7[6], funct7[4:0]};

    always_comb begin
        // NOTE: every output gets a default first, so no path through the case infers a latch.
        ctrl       = CTRL_NOP;
        use_rs1    = 1'b0;
        use_rs2    = 1'b0;
        illegal    = 1'b0;
        ctrl.valid = 1'b1;
        ctrl.rd    = rd;
        case (opcode)
            OP_R: begin
                ctrl.RuWr  = 1'b1;
                ctrl.ALUOp = {funct7[5], funct3};
                use_rs1    = 1'b1;
                use_rs2    = 1'b1;
            end
            OP_I: begin
                ctrl.AluBSrc = 1'b1;
                ctrl.ImmSrc  = IMM_I;
                ctrl.RuWr    = 1'b1;
                ctrl.ALUOp   = (funct3 == 3'b101) ? {funct7[5], funct3} : {1'b0, funct3};
                use_rs1      = 1'b1;
            end
            OP_LOAD: begin
                ctrl.AluBSrc     = 1'b1;
                ctrl.ImmSrc      = IMM_I;
                ctrl.ALUOp       = ALU_ADD;
                ctrl.RuWr        = 1'b1;
                ctrl.DMCtrl      = funct3;
                ctrl.RUDataWrSrc = WB_MEM;
                use_rs1          = 1'b1;
            end
            OP_S: begin
                ctrl.AluBSrc = 1'b1;
                ctrl.ImmSrc  = IMM_S;
                ctrl.ALUOp   = ALU_ADD;
                ctrl.DMWr    = 1'b1;
                ctrl.DMCtrl  = funct3;
                use_rs1      = 1'b1;
                use_rs2      = 1'b1;
            end
            OP_B: begin
                ctrl.AluASrc = 1'b1;
                ctrl.AluBSrc = 1'b1;
                ctrl.ImmSrc  = IMM_B;
                ctrl.ALUOp   = ALU_ADD;
                ctrl.BrOp    = {2'b01, funct3};
                use_rs1      = 1'b1;
                use_rs2      = 1'b1;
            end
            OP_JAL: begin
                ctrl.AluASrc     = 1'b1;
                ctrl.AluBSrc     = 1'b1;
                ctrl.ImmSrc      = IMM_J;
                ctrl.ALUOp       = ALU_ADD;
                ctrl.BrOp        = BR_JUMP;
                ctrl.RuWr        = 1'b1;
                ctrl.RUDataWrSrc = WB_PC4;
            end
            OP_JALR: begin
                ctrl.AluBSrc     = 1'b1;
                ctrl.ImmSrc      = IMM_I;
                ctrl.ALUOp       = ALU_ADD;
                ctrl.BrOp        = BR_JUMP;
                ctrl.RuWr        = 1'b1;
                ctrl.RUDataWrSrc = WB_PC4;
                use_rs1          = 1'b1;
            end
            OP_LUI: begin
                ctrl.AluBSrc = 1'b1;
                ctrl.ImmSrc  = IMM_U;
                ctrl.ALUOp   = ALU_PASSB;
                ctrl.RuWr    = 1'b1;
            end
            OP_AUIPC: begin
                ctrl.AluASrc = 1'b1;
                ctrl.AluBSrc = 1'b1;
                ctrl.ImmSrc  = IMM_U;
                ctrl.ALUOp   = ALU_ADD;
                ctrl.RuWr    = 1'b1;
            end
            default: begin
                ctrl    = CTRL_NOP;
                illegal = id_valid;
            end
        endcase
        // Unread source fields are zeroed so they can never match a producer.
        ctrl.rs1 = use_rs1 ? rs1 : '0;
        ctrl.rs2 = use_rs2 ? rs2 : '0;
    end

endmodule

// File: rtl/pipe_ctrl_unit.sv
// Pipelined control unit: ID decode, ID/EX-EX/MEM-MEM/WB control registers,
// hazard stall/flush and stall counter. Define FORWARD_EN for forwarding mode.
module pipe_ctrl_unit
    import pipe_ctrl_pkg::*;
#(
    parameter int REG_ADDR_W = REG_W,
    parameter int CNT_W      = 16
)(
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  id_valid,
    input  logic [6:0]            opcode,
    input  logic [2:0]            funct3,
    input  logic [6:0]            funct7,
    input  logic [REG_ADDR_W-1:0] rs1,
    input  logic [REG_ADDR_W-1:0] rs2,
    input  logic [REG_ADDR_W-1:0] rd,
    input  logic                  br_taken_ex,
    output ctrl_t                 ex_ctrl,
    output ctrl_t                 mem_ctrl,
    output ctrl_t                 wb_ctrl,
    output logic                  stall_if,
    output logic                  flush_ifid,
    output logic                  illegal,
`ifdef FORWARD_EN
    output logic [1:0]            fwd_a,
    output logic [1:0]            fwd_b,
`endif
    output logic [CNT_W-1:0]      stall_cnt
);

    ctrl_t id_ctrl;
    logic  id_live;
    logic  flush_ex;
    logic  hazard;
    logic  ex_hit;

    pipe_ctrl_decode u_decode (
        .id_valid (id_valid),
        .opcode   (opcode),
        .funct3   (funct3),
        .funct7   (funct7),
        .rs1      (rs1),
        .rs2      (rs2),
        .rd       (rd),
        .ctrl     (id_ctrl),
        .illegal  (illegal)
    );

    assign id_live = id_valid & id_ctrl.valid;
    assign ex_hit  = src_hit(ex_ctrl.valid, ex_ctrl.RuWr, ex_ctrl.rd, id_ctrl.rs1)
                   | src_hit(ex_ctrl.valid, ex_ctrl.RuWr, ex_ctrl.rd, id_ctrl.rs2);

`ifdef FORWARD_EN
    // Only a load still in EX has no value to forward yet.
    assign hazard = id_live & ex_hit & (ex_ctrl.RUDataWrSrc == WB_MEM);

    always_comb begin
        fwd_a = FWD_RF;
        fwd_b = FWD_RF;
        if (src_hit(mem_ctrl.valid, mem_ctrl.RuWr, mem_ctrl.rd, ex_ctrl.rs1))
            fwd_a = FWD_MEM;
        else if (src_hit(wb_ctrl.valid, wb_ctrl.RuWr, wb_ctrl.rd, ex_ctrl.rs1))
            fwd_a = FWD_WB;
        if (src_hit(mem_ctrl.valid, mem_ctrl.RuWr, mem_ctrl.rd, ex_ctrl.rs2))
            fwd_b = FWD_MEM;
        else if (src_hit(wb_ctrl.valid, wb_ctrl.RuWr, wb_ctrl.rd, ex_ctrl.rs2))
            fwd_b = FWD_WB;
    end
`else
    logic mem_hit;
    logic wb_hit;

    assign mem_hit = src_hit(mem_ctrl.valid, mem_ctrl.RuWr, mem_ctrl.rd, id_ctrl.rs1)
                   | src_hit(mem_ctrl.valid, mem_ctrl.RuWr, mem_ctrl.rd, id_ctrl.rs2);
    assign wb_hit  = src_hit(wb_ctrl.valid, wb_ctrl.RuWr, wb_ctrl.rd, id_ctrl.rs1)
                   | src_hit(wb_ctrl.valid, wb_ctrl.RuWr, wb_ctrl.rd, id_ctrl.rs2);
    // Without forwarding the consumer waits until the producer has retired from WB.
    assign hazard  = id_live & (ex_hit | mem_hit | wb_hit);
`endif

    assign flush_ex   = br_taken_ex;
    assign flush_ifid = br_taken_ex;
    assign stall_if   = hazard & ~br_taken_ex;

    always_ff @(posedge clk) begin
        // NOTE: reset is synchronous, so it lives inside the clocked branch, not the sensitivity list.
        if (rst) begin
            ex_ctrl   <= CTRL_NOP;
            mem_ctrl  <= CTRL_NOP;
            wb_ctrl   <= CTRL_NOP;
            stall_cnt <= '0;
        end else begin
            ex_ctrl  <= (flush_ex | hazard | ~id_valid) ? CTRL_NOP : id_ctrl;
            mem_ctrl <= ex_ctrl;
            wb_ctrl  <= mem_ctrl;
            if (stall_if && stall_cnt != '1)
                stall_cnt <= stall_cnt + 1'b1;
        end
    end

endmodule
